// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO block: register word offsets,
// bus request payload, handshake states and byte-lane mask expansion.
package wb_gpio_pkg;

  localparam int unsigned ADDR_BITS = 4;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SEL_W     = DATA_W / 8;

  localparam logic [ADDR_BITS-1:0] ADDR_IN         = 4'h0;
  localparam logic [ADDR_BITS-1:0] ADDR_OUT        = 4'h1;
  localparam logic [ADDR_BITS-1:0] ADDR_OE         = 4'h2;
  localparam logic [ADDR_BITS-1:0] ADDR_OUT_SET    = 4'h3;
  localparam logic [ADDR_BITS-1:0] ADDR_OUT_CLR    = 4'h4;
  localparam logic [ADDR_BITS-1:0] ADDR_OUT_TGL    = 4'h5;
  localparam logic [ADDR_BITS-1:0] ADDR_RISE_EN    = 4'h6;
  localparam logic [ADDR_BITS-1:0] ADDR_FALL_EN    = 4'h7;
  localparam logic [ADDR_BITS-1:0] ADDR_IRQ_STATUS = 4'h8;

  typedef enum logic [0:0] {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic                 we;
    logic [ADDR_BITS-1:0] idx;
    logic [DATA_W-1:0]    dat;
    logic [SEL_W-1:0]     sel;
  } wb_req_t;

  // Expand one enable bit per byte lane into a full-width bit mask.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [SEL_W-1:0] sel);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < SEL_W; i++) begin
      m[i*8 +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage synchroniser for an asynchronous vector with one-cycle
// rising/falling edge pulses derived from the synchronised value.
module gpio_sync_edge #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;
  logic [WIDTH-1:0]             prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      prev_q  <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], din};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign sync = chain_q[STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/wb_gpio.sv
// Wishbone B4 classic GPIO slave: direction, atomic output updates and
// sticky edge interrupts with write-1-to-clear status.
module wb_gpio
  import wb_gpio_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  irq_o
);

  localparam int unsigned W = GPIO_WIDTH;

  bus_state_e       state_q, state_d;
  logic             commit_c;
  wb_req_t          req_c;
  logic             unused_c;
  logic [DATA_W-1:0] lane_c;
  logic [W-1:0]     mask_c, wdat_c, w1c_c;
  logic [W-1:0]     sync_c, rise_c, fall_c;
  logic [W-1:0]     out_q, oe_q, rise_en_q, fall_en_q, status_q;
  logic [W-1:0]     out_d, oe_d, rise_en_d, fall_en_d, status_d;
  logic [DATA_W-1:0] rdata_c, dat_q;
  logic             irq_q;

  assign req_c    = '{we: wb_we_i, idx: wb_adr_i[5:2], dat: wb_dat_i, sel: wb_sel_i};
  assign unused_c = ^{wb_adr_i[31:6], wb_adr_i[1:0]};
  assign lane_c   = lane_mask(req_c.sel);
  assign mask_c   = lane_c[W-1:0];
  assign wdat_c   = req_c.dat[W-1:0] & mask_c;

  gpio_sync_edge #(.WIDTH(W), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .din   (gpio_i),
    .sync  (sync_c),
    .rise  (rise_c),
    .fall  (fall_c)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= BUS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: if (wb_cyc_i && wb_stb_i) state_d = BUS_ACK;
      BUS_ACK:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  // A request is accepted only from idle, so held strobes ack every other cycle.
  always_comb begin
    commit_c = 1'b0;
    if (state_q == BUS_IDLE && wb_cyc_i && wb_stb_i) commit_c = 1'b1;
  end

  // Register updates; edge sets are ORed in after the W1C so a set wins.
  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_c     = '0;
    if (commit_c && req_c.we) begin
      case (req_c.idx)
        ADDR_OUT:        out_d     = (out_q & ~mask_c) | wdat_c;
        ADDR_OE:         oe_d      = (oe_q & ~mask_c) | wdat_c;
        ADDR_OUT_SET:    out_d     = out_q | wdat_c;
        ADDR_OUT_CLR:    out_d     = out_q & ~wdat_c;
        ADDR_OUT_TGL:    out_d     = out_q ^ wdat_c;
        ADDR_RISE_EN:    rise_en_d = (rise_en_q & ~mask_c) | wdat_c;
        ADDR_FALL_EN:    fall_en_d = (fall_en_q & ~mask_c) | wdat_c;
        ADDR_IRQ_STATUS: w1c_c     = wdat_c;
        default: ;
      endcase
    end
    status_d = (status_q & ~w1c_c) | (rise_c & rise_en_q) | (fall_c & fall_en_q);
  end

  always_comb begin
    rdata_c = '0;
    case (req_c.idx)
      ADDR_IN:         rdata_c = DATA_W'(sync_c);
      ADDR_OUT:        rdata_c = DATA_W'(out_q);
      ADDR_OE:         rdata_c = DATA_W'(oe_q);
      ADDR_RISE_EN:    rdata_c = DATA_W'(rise_en_q);
      ADDR_FALL_EN:    rdata_c = DATA_W'(fall_en_q);
      ADDR_IRQ_STATUS: rdata_c = DATA_W'(status_q);
      default:         rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      irq_q     <= |status_d;
      if (commit_c) dat_q <= rdata_c;
    end
  end

  assign wb_ack_o  = (state_q == BUS_ACK);
  assign wb_dat_o  = dat_q;
  assign gpio_o    = out_q;
  assign gpio_oe_o = oe_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_gpio.sv
// Self-checking bench for wb_gpio: vector table, hand-timed corner cases and
// randomized traffic against a register-level reference model.
module tb_wb_gpio;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat, wb_dat_o, dat8_o;
  logic [3:0]  wb_sel;
  logic        wb_ack, ack8;
  logic [31:0] gpio_i, gpio_o, gpio_oe;
  logic [7:0]  gpio8_o, gpio8_oe;
  logic        irq, irq8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_gpio #(.GPIO_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .wb_we_i(wb_we), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack), .gpio_i(gpio_i), .gpio_o(gpio_o),
    .gpio_oe_o(gpio_oe), .irq_o(irq)
  );

  wb_gpio #(.GPIO_WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .wb_we_i(wb_we), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
    .wb_dat_o(dat8_o), .wb_ack_o(ack8), .gpio_i(gpio_i[7:0]), .gpio_o(gpio8_o),
    .gpio_oe_o(gpio8_oe), .irq_o(irq8)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bytes_of(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (sel[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Called one time unit after a rising edge with the bus idle; returns likewise.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd, output logic [31:0] rd8);
    bit got;
    got = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (wb_ack) begin got = 1'b1; break; end
    end
    if (!got) check("ack_timeout", 32'(wb_ack), 32'd1);
    rd = wb_dat_o; rd8 = dat8_o;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = '0; wb_dat = '0; wb_sel = '0; gpio_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, rd8;
    logic [31:0] m_out, m_oe, m_rise, m_fall, m_stat, m_in, newg, m, d, exp;
    int          idx;
    logic        we;
    logic [3:0]  sel;

    // Vector table: reset reads, output atomics, lane masking, unmapped offsets.
    for (int a = 0; a < 16; a++) tbl.push_back('{1'b0, 32'(a*4), 32'h0, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 32'h04, 32'h0000_00F0, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 32'h0C, 32'h0000_000F, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 32'h10, 32'h0000_0030, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 32'h14, 32'h0000_0081, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h04, 32'h0,         4'hF, 32'h0000_004E});
    tbl.push_back('{1'b0, 32'h0C, 32'h0,         4'hF, 32'h0});
    tbl.push_back('{1'b1, 32'h04, 32'h0,         4'hF, 32'h0});
    tbl.push_back('{1'b1, 32'h04, 32'hFFFF_FFFF, 4'b0010, 32'h0});
    tbl.push_back('{1'b0, 32'h04, 32'h0,         4'hF, 32'h0000_FF00});
    tbl.push_back('{1'b1, 32'h08, 32'h0000_A5A5, 4'b0001, 32'h0});
    tbl.push_back('{1'b0, 32'h08, 32'h0,         4'hF, 32'h0000_00A5});
    tbl.push_back('{1'b1, 32'h3C, 32'hDEAD_BEEF, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h3C, 32'h0,         4'hF, 32'h0});
    tbl.push_back('{1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 32'h04, 32'h0,         4'hF, 32'hFFFF_FFFF});

    do_reset();
    check("rst_gpio_o", gpio_o, 32'h0);
    check("rst_gpio_oe", gpio_oe, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ack", 32'(wb_ack), 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);

    foreach (tbl[i]) begin
      xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd, rd8);
      if (!tbl[i].we) check($sformatf("tbl%0d_rd_%h", i, tbl[i].adr), rd, tbl[i].exp);
    end
    check("oe_pins", gpio_oe, 32'h0000_00A5);
    // Narrow instance saw the same traffic: only its 8 implemented bits stick.
    check("w8_out_read", rd8, 32'h0000_00FF);
    check("w8_gpio_o", 32'(gpio8_o), 32'h0000_00FF);

    // Input latency: pin driven after edge E0, IN still 0 at E2, status set at E3.
    do_reset();
    xfer(1'b1, 32'h18, 32'h1, 4'hF, rd, rd8);
    gpio_i[0] = 1'b1;
    @(posedge clk); #1;
    check("lat_irq_e1", 32'(irq), 32'h0);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h00;
    @(posedge clk); #1;
    check("lat_ack_e2", 32'(wb_ack), 32'h1);
    check("lat_in_e2", wb_dat_o & 32'h1, 32'h0);
    check("lat_irq_e2", 32'(irq), 32'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    check("lat_irq_e3", 32'(irq), 32'h1);
    xfer(1'b0, 32'h00, 32'h0, 4'hF, rd, rd8);
    check("lat_in_after", rd, 32'h1);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, rd8);
    check("lat_status", rd, 32'h1);

    // Rise on a bit without its enable leaves status alone.
    gpio_i[1] = 1'b1;
    repeat (6) @(posedge clk); #1;
    xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, rd8);
    check("unen_status", rd, 32'h1);
    xfer(1'b0, 32'h00, 32'h0, 4'hF, rd, rd8);
    check("unen_in", rd, 32'h3);

    // Fall on bit 1 with FALL_EN -> status 0x3, then W1C bit 0.
    xfer(1'b1, 32'h1C, 32'h2, 4'hF, rd, rd8);
    gpio_i[1] = 1'b0;
    repeat (6) @(posedge clk); #1;
    xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, rd8);
    check("fall_status", rd, 32'h3);
    xfer(1'b1, 32'h20, 32'h1, 4'hF, rd, rd8);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, rd8);
    check("w1c_status", rd, 32'h2);
    check("w1c_irq", 32'(irq), 32'h1);

    // W1C of bit 1 committing on the same edge a new fall on bit 1 sets it.
    gpio_i[1] = 1'b1;
    repeat (6) @(posedge clk); #1;
    gpio_i[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h20; wb_dat = 32'h2; wb_sel = 4'hF;
    @(posedge clk); #1;
    check("coll_ack", 32'(wb_ack), 32'h1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, rd8);
    check("coll_status", rd, 32'h2);
    xfer(1'b1, 32'h20, 32'h2, 4'hF, rd, rd8);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, rd8);
    check("clr_all_status", rd, 32'h0);
    check("clr_all_irq", 32'(irq), 32'h0);

    // Held strobe: ack on alternate cycles, one cycle wide.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h04;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("held_ack_c%0d", c), 32'(wb_ack), (c % 2 == 0) ? 32'h1 : 32'h0);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;

    // Reset while a write waits for ack: nothing commits.
    xfer(1'b1, 32'h04, 32'h0000_0011, 4'hF, rd, rd8);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h04; wb_dat = 32'h55; wb_sel = 4'hF;
    #2 rst_n = 1'b0;
    #1 check("rst_pend_ack", 32'(wb_ack), 32'h0);
    @(posedge clk); #1;
    check("rst_pend_ack_edge", 32'(wb_ack), 32'h0);
    check("rst_pend_gpio_o", gpio_o, 32'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 32'h04, 32'h0, 4'hF, rd, rd8);
    check("rst_pend_out", rd, 32'h0);

    // Reset during the ack cycle drops ack at once.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h04;
    @(posedge clk); #1;
    check("rst_ack_hi", 32'(wb_ack), 32'h1);
    rst_n = 1'b0;
    #1 check("rst_ack_drop", 32'(wb_ack), 32'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the register-level model.
    do_reset();
    m_out = '0; m_oe = '0; m_rise = '0; m_fall = '0; m_stat = '0; m_in = '0;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        newg = m_in ^ ($urandom & $urandom);
        m_stat = m_stat | (newg & ~m_in & m_rise) | (~newg & m_in & m_fall);
        m_in = newg;
        gpio_i = newg;
        repeat (6) @(posedge clk); #1;
      end else begin
        idx = int'($urandom_range(0, 10));
        if (idx > 8) idx = int'($urandom_range(9, 15));
        we  = 1'($urandom_range(0, 1));
        d   = $urandom;
        sel = 4'($urandom);
        xfer(we, 32'(idx * 4), d, sel, rd, rd8);
        m = bytes_of(sel);
        if (we) begin
          case (idx)
            1: m_out  = (m_out & ~m) | (d & m);
            2: m_oe   = (m_oe & ~m) | (d & m);
            3: m_out  = m_out | (d & m);
            4: m_out  = m_out & ~(d & m);
            5: m_out  = m_out ^ (d & m);
            6: m_rise = (m_rise & ~m) | (d & m);
            7: m_fall = (m_fall & ~m) | (d & m);
            8: m_stat = m_stat & ~(d & m);
            default: ;
          endcase
        end else begin
          case (idx)
            0: exp = m_in;
            1: exp = m_out;
            2: exp = m_oe;
            6: exp = m_rise;
            7: exp = m_fall;
            8: exp = m_stat;
            default: exp = 32'h0;
          endcase
          check($sformatf("rnd%0d_rd_off%0d", it, idx), rd, exp);
        end
      end
      check($sformatf("rnd%0d_gpio_o", it), gpio_o, m_out);
      check($sformatf("rnd%0d_gpio_oe", it), gpio_oe, m_oe);
      check($sformatf("rnd%0d_irq", it), 32'(irq), (m_stat != 0) ? 32'h1 : 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
